// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// The owner of the memory bus is encoded directly in the arbiter state.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        ERR
    } arb_state_t;

    typedef enum logic {
        PORT_IF,
        PORT_DM
    } port_id_t;

    function automatic port_id_t busy_port(arb_state_t s);
        return (s == BUSY_DM) ? PORT_DM : PORT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, data port, memory bus and status signals around the arbiter.
// slave is the arbiter's view; master is the CPU/memory side.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              stall;
    logic              timeout_err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, stall, timeout_err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall, timeout_err
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Saturating watchdog counter for cycles spent waiting on mem_ready.
// expired flags the waiting cycle that brings the count up to TIMEOUT.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int            CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = count_en && (count >= LIMIT - 1'b1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between fetch and data ports,
// data first, with registered bus outputs, one-cycle acks and a wait watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0] NO_ADDR = '0;
    localparam logic [DATA_W-1:0] NO_DATA = '0;

    arb_state_t state;
    logic       dm_eligible;
    logic       if_eligible;
    logic       busy;
    logic       grant;
    logic       complete;
    logic       expired;

    // A request seen alongside its own ack is the one just served, not a new one.
    assign dm_eligible = bus.dm_req & ~bus.dm_ack;
    assign if_eligible = bus.if_req & ~bus.if_ack;
    assign busy        = (state == BUSY_IF) || (state == BUSY_DM);
    assign grant       = (state == IDLE) && (dm_eligible || if_eligible);
    assign complete    = busy && bus.mem_ready;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (grant | complete),
        .count_en (busy & ~bus.mem_ready),
        .expired  (expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= NO_ADDR;
            bus.mem_wdata   <= NO_DATA;
            bus.if_ack      <= 1'b0;
            bus.dm_ack      <= 1'b0;
            bus.if_rdata    <= NO_DATA;
            bus.dm_rdata    <= NO_DATA;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.dm_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (dm_eligible) begin
                        state         <= BUSY_DM;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.dm_we;
                        bus.mem_addr  <= bus.dm_addr;
                        bus.mem_wdata <= bus.dm_wdata;
                    end else if (if_eligible) begin
                        state         <= BUSY_IF;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= NO_DATA;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (bus.mem_ready) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        if (busy_port(state) == PORT_DM) begin
                            bus.dm_ack <= 1'b1;
                            if (!bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
                        end else begin
                            bus.if_ack   <= 1'b1;
                            bus.if_rdata <= bus.mem_rdata;
                        end
                    end else if (expired) begin
                        state           <= ERR;
                        bus.mem_req     <= 1'b0;
                        bus.mem_we      <= 1'b0;
                        bus.timeout_err <= 1'b1;
                    end
                end
                ERR: begin
                    bus.mem_req     <= 1'b0;
                    bus.timeout_err <= 1'b1;
                end
                default: state <= ERR;
            endcase
        end
    end

    assign bus.stall = (bus.if_req & ~bus.if_ack) | (bus.dm_req & ~bus.dm_ack) | (state == ERR);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected grants/acks into a
// scoreboard queue that a negedge monitor pops whenever the DUT presents one.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    typedef enum int {EV_GRANT, EV_ACK_IF, EV_ACK_DM} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t0    = 0;
    ev_t  sbq[$];

    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_dm_rdata = '0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_kind_t k, input int c, input logic [31:0] a,
                        input logic w, input logic [31:0] d);
        ev_t e;
        e.kind = k; e.cyc = c; e.addr = a; e.we = w; e.data = d;
        sbq.push_back(e);
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [31:0] a,
                             input logic w, input logic [31:0] d);
        ev_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_%s: got event at cycle %0d, required none", k.name(), cyc);
            return;
        end
        e = sbq.pop_front();
        check({k.name(), "_kind"}, 64'(k), 64'(e.kind));
        check({k.name(), "_cycle"}, 64'(cyc), 64'(e.cyc));
        if (k == EV_GRANT) begin
            check("grant_addr", a, e.addr);
            check("grant_we", w, e.we);
            check("grant_wdata", d, e.data);
        end else begin
            check({k.name(), "_rdata"}, d, e.data);
        end
    endtask

    // Monitor: consumes one scoreboard entry per ack pulse or mem_req rising edge.
    logic        prev_req = 1'b0;
    logic [31:0] hold_addr, hold_wdata;
    logic        hold_we;

    always @(negedge clock) begin
        if (reset) begin
            if (bus.if_ack) expect_ev(EV_ACK_IF, '0, 1'b0, bus.if_rdata);
            if (bus.dm_ack) expect_ev(EV_ACK_DM, '0, 1'b0, bus.dm_rdata);
            if (bus.mem_req && !prev_req) begin
                expect_ev(EV_GRANT, bus.mem_addr, bus.mem_we, bus.mem_wdata);
                hold_addr  <= bus.mem_addr;
                hold_we    <= bus.mem_we;
                hold_wdata <= bus.mem_wdata;
            end else if (bus.mem_req) begin
                check("stable_addr", bus.mem_addr, hold_addr);
                check("stable_we", bus.mem_we, hold_we);
                check("stable_wdata", bus.mem_wdata, hold_wdata);
            end
            prev_req <= bus.mem_req;
        end else begin
            prev_req <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, bus.mem_req, 0);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_if_ack"}, bus.if_ack, 0);
        check({tag, "_dm_ack"}, bus.dm_ack, 0);
        check({tag, "_if_rdata"}, bus.if_rdata, 0);
        check({tag, "_dm_rdata"}, bus.dm_rdata, 0);
        check({tag, "_timeout_err"}, bus.timeout_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        bus.if_req = 0; bus.if_addr = '0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 0;

        // Reset state
        #1 reset = 1'b0;
        #1;
        check_all_zero("rst");
        check("rst_stall", bus.stall, 0);
        #10 reset = 1'b1;

        // 1: fetch only, zero-wait memory
        step(); t0 = cyc;
        bus.if_req = 1; bus.if_addr = 32'h100; bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
        push(EV_GRANT, t0 + 1, 32'h100, 1'b0, 32'h0);
        push(EV_ACK_IF, t0 + 2, '0, 1'b0, 32'hDEADBEEF);
        exp_if_rdata = 32'hDEADBEEF;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) step();
            if (k == 3) bus.if_req = 0;
            #3;
            check("t1_stall", bus.stall, (k < 2));
        end

        // 2: simultaneous requests, data write wins, fetch follows
        step(); t0 = cyc;
        bus.if_req = 1; bus.if_addr = 32'h100;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h200; bus.dm_wdata = 32'h12345678;
        bus.mem_ready = 1; bus.mem_rdata = 32'hCAFEF00D;
        push(EV_GRANT, t0 + 1, 32'h200, 1'b1, 32'h12345678);
        push(EV_ACK_DM, t0 + 2, '0, 1'b0, exp_dm_rdata);
        push(EV_GRANT, t0 + 3, 32'h100, 1'b0, 32'h0);
        push(EV_ACK_IF, t0 + 4, '0, 1'b0, 32'hCAFEF00D);
        exp_if_rdata = 32'hCAFEF00D;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) step();
            if (k == 3) begin bus.dm_req = 0; bus.dm_we = 0; end
            if (k == 5) bus.if_req = 0;
            #3;
            check("t2_stall", bus.stall, (k <= 3));
            if (k == 1) check("t2_mem_we_c1", bus.mem_we, 1);
            if (k == 3) check("t2_mem_we_c3", bus.mem_we, 0);
            if (k == 4) check("t2_dm_rdata_kept", bus.dm_rdata, exp_dm_rdata);
        end

        // 3: data read with three wait cycles
        step(); t0 = cyc;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h300; bus.dm_wdata = 32'hFFFF0000;
        bus.mem_ready = 0; bus.mem_rdata = 32'hA5A50003;
        push(EV_GRANT, t0 + 1, 32'h300, 1'b0, 32'hFFFF0000);
        push(EV_ACK_DM, t0 + 5, '0, 1'b0, 32'hA5A50003);
        exp_dm_rdata = 32'hA5A50003;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) step();
            if (k == 4) bus.mem_ready = 1;
            if (k == 6) bus.dm_req = 0;
            #3;
            check("t3_stall", bus.stall, (k <= 4));
            check("t3_mem_req", bus.mem_req, (k >= 1 && k <= 4));
        end

        // 6: requester drops dm_req mid-transaction, four wait cycles
        step(); t0 = cyc;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h600; bus.dm_wdata = 32'h0;
        bus.mem_ready = 0; bus.mem_rdata = 32'h0BADF00D;
        push(EV_GRANT, t0 + 1, 32'h600, 1'b0, 32'h0);
        push(EV_ACK_DM, t0 + 6, '0, 1'b0, 32'h0BADF00D);
        exp_dm_rdata = 32'h0BADF00D;
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) step();
            if (k == 2) bus.dm_req = 0;
            if (k == 5) bus.mem_ready = 1;
            #3;
            check("t6_stall", bus.stall, (k < 2));
            check("t6_mem_req", bus.mem_req, (k >= 1 && k <= 5));
        end
        check("t6_dm_rdata", bus.dm_rdata, 32'h0BADF00D);

        // 5: asynchronous reset in the middle of a data write
        step(); t0 = cyc;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h900; bus.dm_wdata = 32'h55AA55AA;
        bus.mem_ready = 0;
        push(EV_GRANT, t0 + 1, 32'h900, 1'b1, 32'h55AA55AA);
        step();
        step();
        #2 reset = 1'b0;
        #1;
        check_all_zero("t5_rst");
        bus.dm_req = 0; bus.dm_we = 0;
        exp_if_rdata = '0; exp_dm_rdata = '0;
        step();
        check("t5_rst_hold_mem_req", bus.mem_req, 0);
        check("t5_rst_hold_stall", bus.stall, 0);
        #2 reset = 1'b1;
        step(); t0 = cyc;
        bus.if_req = 1; bus.if_addr = 32'hA00; bus.mem_ready = 1; bus.mem_rdata = 32'h13579BDF;
        push(EV_GRANT, t0 + 1, 32'hA00, 1'b0, 32'h0);
        push(EV_ACK_IF, t0 + 2, '0, 1'b0, 32'h13579BDF);
        exp_if_rdata = 32'h13579BDF;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) step();
            if (k == 3) bus.if_req = 0;
            #3;
            check("t5_stall", bus.stall, (k < 2));
        end

        // 4: memory never answers, watchdog trips, later requests ignored
        step(); t0 = cyc;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h700; bus.dm_wdata = 32'h0;
        bus.mem_ready = 0;
        push(EV_GRANT, t0 + 1, 32'h700, 1'b0, 32'h0);
        for (int k = 0; k <= 22; k++) begin
            if (k > 0) step();
            if (k == 17) begin bus.dm_req = 0; bus.if_req = 1; bus.if_addr = 32'h800; end
            if (k == 20) bus.if_req = 0;
            #3;
            check("t4_mem_req", bus.mem_req, (k >= 1 && k <= 15));
            check("t4_timeout_err", bus.timeout_err, (k >= 16));
            check("t4_stall", bus.stall, 1);
            if (k >= 16) check("t4_no_ack", {bus.if_ack, bus.dm_ack}, 0);
        end

        // ERR exits only through reset
        #2 reset = 1'b0;
        #1;
        check_all_zero("final_rst");
        check("final_rst_stall", bus.stall, 0);
        step();
        #2 reset = 1'b1;
        step();
        step();
        check("sb_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the CPU's single-ported unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage). It arbitrates, registers the granted request onto the memory bus, and tolerates variable-latency `mem_ready` responses. It returns read data with a one-cycle ack pulse and drives a pipeline `stall` to the datapath. A watchdog flags a memory that never answers.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 15, max consecutive cycles `mem_req` may wait for `mem_ready` before error

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
if_req  in  1  fetch request; held until if_ack
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, valid while if_ack=1, held afterwards
if_ack  out  1  one-cycle completion pulse, fetch port
dm_req  in  1  data request; held until dm_ack
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_rdata  out  DATA_W  load data, valid while dm_ack=1, held afterwards
dm_ack  out  1  one-cycle completion pulse, data port
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1
mem_ready  in  1  memory completion, same-cycle response allowed
stall  out  1  pipeline freeze to datapath
timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset (async, reset=0):
  - state IDLE; wait counter 0.
  - All outputs 0, including rdata registers and timeout_err.
  - mem_req drops immediately. An in-flight transaction is abandoned with no ack.
- FSM states: IDLE, BUSY_IF, BUSY_DM, ERR.
- IDLE, requests considered: a port's req is ignored in any cycle where its own ack=1 (request consumed).
- IDLE arbitration, fixed priority, data over fetch:
  - eligible dm_req → BUSY_DM; register mem_addr=dm_addr, mem_we=dm_we, mem_wdata=dm_wdata, mem_req=1.
  - else eligible if_req → BUSY_IF; register mem_addr=if_addr, mem_we=0, mem_wdata=0, mem_req=1.
  - else stay IDLE.
- BUSY_x, mem_ready=1 in the same cycle:
  - next edge: mem_req=0, mem_we=0.
  - x_ack=1 for exactly one cycle.
  - reads: x_rdata←mem_rdata. Writes leave dm_rdata unchanged.
  - state → IDLE.
- Minimum latency: req sampled in cycle N → mem_req high in N+1 → ack in N+2 (zero-wait memory).
- A requester dropping req mid-transaction does not abort it: the ack still pulses and rdata still updates.
- Watchdog:
  - counter increments each BUSY cycle with mem_ready=0; it clears on grant and on completion.
  - when the counter reaches TIMEOUT → ERR.
- ERR:
  - mem_req=0; timeout_err=1; no acks; all requests ignored.
  - exit only via reset.
- stall (combinational) = (if_req & ~if_ack) | (dm_req & ~dm_ack) | (state==ERR).
- mem_addr, mem_we and mem_wdata are stable for the entire time mem_req=1.
- Counter width = $clog2(TIMEOUT+1). No wrap: it saturates at TIMEOUT.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, BUSY_IF, BUSY_DM, ERR}.
  - port_id_t enum {PORT_IF, PORT_DM}.
  - default ADDR_W and DATA_W constants.
- Sub-module: mem_wait_timer, holding the saturating watchdog counter. Inputs: clear, count_en. Output: expired. Parameter: TIMEOUT.

Test Plan:
1. Fetch only, mem_ready=1, if_req at cycle 0, if_addr=0x100, mem_rdata=0xDEADBEEF → mem_req=1 / mem_addr=0x100 in cycle 1; if_ack=1 with if_rdata=0xDEADBEEF in cycle 2; stall=1 in cycles 0–1, 0 in cycle 2.
2. if_req and dm_req (write, 0x200, 0x12345678) both at cycle 0, mem_ready=1 →
   - cycle 1: mem_we=1, mem_addr=0x200, mem_wdata=0x12345678.
   - cycle 2: dm_ack; fetch granted.
   - cycle 3: mem_addr=0x100, mem_we=0.
   - cycle 4: if_ack; dm_rdata unchanged.
3. Data read, mem_ready low for 3 cycles then high → mem_req high cycles 1–4; dm_ack in cycle 5; mem_addr constant throughout; stall high cycles 0–4.
4. TIMEOUT=15, mem_ready held 0 →
   - ERR after 15 waiting cycles; timeout_err=1; mem_req=0; stall=1; no acks.
   - later requests ignored until reset.
5. reset driven low mid-BUSY_DM (asynchronous, between edges) → all outputs 0 immediately, no dm_ack. After release, a new fetch completes with 2-cycle latency.
6. dm_req dropped in cycle 2 of a 4-wait read → transaction completes; dm_ack pulses once; dm_rdata updated; no second grant; stall=0 after completion.
